// File: rtl/regfile_write_arbiter_if.sv
// Loader request channel into the register-file write arbiter.
// The loader drives valid/addr/data and the arbiter returns ready.
interface regfile_write_arbiter_if;
   logic        ld_valid;
   logic        ld_ready;
   logic [3:0]  ld_addr;
   logic [31:0] ld_data;

   modport master (output ld_valid, output ld_addr, output ld_data, input ld_ready);
   modport slave  (input ld_valid, input ld_addr, input ld_data, output ld_ready);
endinterface

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between pipeline writeback (priority)
// and a FIFO-buffered loader, with starvation stall and read-hazard flags.
module regfile_write_arbiter #(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 4,
   parameter int unsigned DROP_W   = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wb_we,
   input  logic [3:0]            wb_addr,
   input  logic [31:0]           wb_data,
   regfile_write_arbiter_if.slave ld,
   input  logic [3:0]            rn,
   input  logic [3:0]            rm,
   output logic                  WE3,
   output logic [3:0]            rf_waddr,
   output logic [31:0]           rf_wdata,
   output logic                  stall_req,
   output logic                  rd_hazard,
   output logic [DROP_W-1:0]     drop_cnt
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);

   logic [3:0]        addr_mem_q [DEPTH];
   logic [31:0]       data_mem_q [DEPTH];
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW:0]       count_q, count_d;
   logic [WW-1:0]     wait_q, wait_d;
   logic [DROP_W-1:0] drop_q, drop_d;

   logic full, empty, xfer, is_pc, push, grant;

   assign full  = (count_q == (AW+1)'(DEPTH));
   assign empty = (count_q == '0);
   assign ld.ld_ready = !full;
   assign xfer  = ld.ld_valid && !full;
   assign is_pc = (ld.ld_addr == 4'hF);
   assign push  = xfer && !is_pc;
   assign grant = !wb_we && !empty;

   assign stall_req = (wait_q == WW'(MAX_WAIT));
   assign drop_cnt  = drop_q;

   always_comb begin
      WE3      = 1'b0;
      rf_waddr = '0;
      rf_wdata = '0;
      if (wb_we) begin
         WE3      = 1'b1;
         rf_waddr = wb_addr;
         rf_wdata = wb_data;
      end else if (!empty) begin
         WE3      = 1'b1;
         rf_waddr = addr_mem_q[rd_ptr_q];
         rf_wdata = data_mem_q[rd_ptr_q];
      end
   end

   // An entry is live when its distance from the head is below the occupancy.
   always_comb begin
      logic [AW-1:0] off;
      rd_hazard = 1'b0;
      off       = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         off = AW'(i) - rd_ptr_q;
         if (({1'b0, off} < count_q) &&
             ((addr_mem_q[i] == rn) || (addr_mem_q[i] == rm)))
            rd_hazard = 1'b1;
      end
   end

   always_comb begin
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      wait_d   = wait_q;
      drop_d   = drop_q;

      if (grant) rd_ptr_d = rd_ptr_q + AW'(1);
      if (push)  wr_ptr_d = wr_ptr_q + AW'(1);

      case ({push, grant})
         2'b10:   count_d = count_q + (AW+1)'(1);
         2'b01:   count_d = count_q - (AW+1)'(1);
         default: count_d = count_q;
      endcase

      if (empty || grant)
         wait_d = '0;
      else if (wb_we && (wait_q != WW'(MAX_WAIT)))
         wait_d = wait_q + WW'(1);

      if (xfer && is_pc && (drop_q != '1))
         drop_d = drop_q + DROP_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         wait_q   <= '0;
         drop_q   <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
         wait_q   <= wait_d;
         drop_q   <= drop_d;
      end
   end

   // Storage needs no reset: liveness is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (push) begin
         addr_mem_q[wr_ptr_q] <= ld.ld_addr;
         data_mem_q[wr_ptr_q] <= ld.ld_data;
      end
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the Decode-stage register file's single write port (WE3/Rd/WD3) between the pipeline writeback path and the calculator operand loader.
- Pipeline writeback always has priority.
- Loader writes are buffered in a small FIFO and drained into idle write-port cycles.
- The block also raises a starvation stall request to the pipeline, and flags read hazards against queued loader writes.

Parameters:
DEPTH, 2, loader FIFO entries (power of two, >=2)
MAX_WAIT, 4, consecutive denied cycles before stall_req asserts (>=1)
DROP_W, 8, width of saturating dropped-write counter

Ports:
clk  in  1  system clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
wb_we  in  1  pipeline writeback enable
wb_addr  in  4  pipeline writeback register
wb_data  in  32  pipeline writeback data
ld_valid  in  1  loader request valid
ld_ready  out  1  loader request accepted this cycle when ld_valid&ld_ready
ld_addr  in  4  loader destination register
ld_data  in  32  loader data
rn  in  4  Decode read address 1
rm  in  4  Decode read address 2
WE3  out  1  register file write enable
rf_waddr  out  4  register file write address (drives Rd port)
rf_wdata  out  32  register file write data (drives WD3)
stall_req  out  1  request pipeline to hold writeback so loader can drain
rd_hazard  out  1  rn or rm matches a queued loader address
drop_cnt  out  DROP_W  count of rejected loader writes to R15

Behaviour:
- Reset (synchronous, active-high), next rising edge:
  - FIFO empty; wait_cnt=0; drop_cnt=0.
  - Outputs therefore read ld_ready=1, WE3=0, rf_waddr=0, rf_wdata=0, stall_req=0, rd_hazard=0.
  - Reset mid-drain discards all queued entries; no partial write is issued afterwards.
- Write port (combinational from current inputs/state):
  - If wb_we=1: WE3=1, rf_waddr=wb_addr, rf_wdata=wb_data. The loader is denied this cycle.
  - Else if FIFO non-empty: WE3=1, outputs driven from FIFO head. The head pops on that clock edge (grant).
  - Else: WE3=0; rf_waddr and rf_wdata are held at 0.
  - Writeback is never delayed or dropped by this block, including while stall_req=1.
- Loader handshake:
  - ld_ready = !full, derived from registered state only (no combinational path from ld_valid).
  - Transfer occurs when ld_valid & ld_ready at the rising edge. The loader holds ld_addr and ld_data stable until the transfer.
  - ld_addr=15 (PC): transfer completes but nothing is enqueued. drop_cnt increments, saturating at all-ones.
- Pointers and full/empty:
  - Pointers wrap modulo DEPTH. A DEPTH+1-bit occupancy count, or an extra pointer bit, disambiguates full from empty.
  - Push and pop in the same cycle (not full): occupancy unchanged, order preserved.
  - Full: ld_ready=0 even if a pop happens that cycle; ready rises the following cycle.
  - Empty: no bypass. A loader write reaches WE3 no earlier than the cycle after its transfer.
- Starvation:
  - wait_cnt increments each cycle the FIFO is non-empty and wb_we=1, saturating at MAX_WAIT.
  - wait_cnt clears on any grant or when the FIFO is empty.
  - stall_req = (wait_cnt==MAX_WAIT), registered.
  - stall_req drops the cycle after the grant edge.
- Read hazard:
  - rd_hazard=1 (combinational) when rn or rm equals the address of any valid FIFO entry, including the head being written this cycle.
  - R15 never matches, since it is never enqueued.
- Ordering: multiple queued writes to the same register drain in FIFO order, so the last value wins.

Test Plan:
- Reset, then ld_valid=1 with addr=3, data=0x11 while wb_we=0 -> transfer at edge 1; next cycle WE3=1, rf_waddr=3, rf_wdata=0x11; FIFO empty after.
- wb_we=1 (addr=7, data=0x666) held for 6 cycles while loader queues addr=5, data=0x22 -> WE3 shows writeback every cycle; stall_req rises 4 cycles after enqueue; first wb_we=0 cycle writes R5=0x22; stall_req=0 next cycle.
- Loader pushes 3 requests back-to-back with wb_we=1 -> ld_ready=0 after 2 transfers; third transfers only the cycle after the first pop.
- Loader writes addr=15, data=0x4 -> handshake completes, WE3 stays 0, drop_cnt=1; 300 such writes -> drop_cnt saturates at 255.
- Queue addr=9 behind wb_we=1, set rn=9 -> rd_hazard=1; after drain, rd_hazard=0; rm=9 gives the same result.
- Two entries queued, assert reset for one cycle -> no further WE3 from the loader; ld_ready=1; stall_req=0; drop_cnt=0.
